regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_if.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Writeback bus between the requesters (execute/memory stages) and the
// register-file write-port arbiter.
interface regfile_wb_if #(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    wb_stall;
    logic [NUM_REGS-1:0]     reg_en;
    logic [DATA_W-1:0]       wb_data;
    logic [2:0]              wb_grant;
    logic [15:0]             wb_count;

    modport master (
        output req_valid, req_addr, req_data, wb_stall,
        input  req_ready, reg_en, wb_data, wb_grant, wb_count
    );

    modport slave (
        input  req_valid, req_addr, req_data, wb_stall,
        output req_ready, reg_en, wb_data, wb_grant, wb_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates N_REQ writeback sources onto the single register-file write port.
// RR_ARB_EN defined: round-robin from ptr; undefined: fixed priority (lowest index wins).
module regfile_wb_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_wb_if.slave  bus
);

    logic [7:0]        valid_pad;
    logic [ADDR_W-1:0] addr_pad [8];
    logic [DATA_W-1:0] data_pad [8];

    logic              grant_found;
    logic [2:0]        grant_idx;
    logic              accept;

    logic [NUM_REGS-1:0] reg_en_reg, reg_en_next;
    logic [DATA_W-1:0]   wb_data_reg;
    logic [2:0]          wb_grant_reg;
    logic [15:0]         wb_count_reg;

    // Pad requester vectors to 8 entries so a 3-bit grant index is always in range.
    assign valid_pad = 8'(bus.req_valid);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < N_REQ) begin : g_live
                assign addr_pad[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
                assign data_pad[gi] = bus.req_data[gi*DATA_W +: DATA_W];
            end else begin : g_absent
                assign addr_pad[gi] = '0;
                assign data_pad[gi] = '0;
            end
        end
    endgenerate

`ifdef RR_ARB_EN
    logic [2:0] ptr_reg, ptr_next;
    logic [3:0] cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_reg} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!grant_found && valid_pad[cand[2:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < 8; k++) begin
            if (!grant_found && valid_pad[k]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(k);
            end
        end
    end
`endif

    assign accept = grant_found & ~bus.wb_stall;

    // Ready is gated by rst_n here only; the flops are already held in reset.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = rst_n & accept & (grant_idx == 3'(gi));
        end
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign reg_en_next[gi] = accept & (addr_pad[grant_idx] == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_en_reg   <= '0;
            wb_data_reg  <= '0;
            wb_grant_reg <= '0;
            wb_count_reg <= '0;
        end else begin
            reg_en_reg <= reg_en_next;
            if (accept) begin
                wb_data_reg  <= data_pad[grant_idx];
                wb_grant_reg <= grant_idx;
                wb_count_reg <= wb_count_reg + 16'd1;
            end
        end
    end

    assign bus.reg_en   = reg_en_reg;
    assign bus.wb_data  = wb_data_reg;
    assign bus.wb_grant = wb_grant_reg;
    assign bus.wb_count = wb_count_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed checks of regfile_wb_arbiter against a transaction-level
// model (pending request table, grant order rule, register file image).
module tb_regfile_wb_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_if #(.N_REQ(N), .DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) bus ();

    regfile_wb_arbiter #(.N_REQ(N), .DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    bit          p_valid [N];
    logic [2:0]  p_addr  [N];
    logic [15:0] p_data  [N];
    bit          stall_m;

    int          ptr_m;
    logic [15:0] cnt_m;
    logic [7:0]  exp_en;
    logic [15:0] exp_data;
    logic [2:0]  exp_grant;
    logic [15:0] rf_m [8];
    logic [15:0] rf_d [8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Winner among pending requests: next in circular order from ptr, or lowest index.
    function automatic int model_pick();
        if (stall_m) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
`ifdef RR_ARB_EN
            i = (ptr_m + k) % N;
`else
            i = k;
`endif
            if (p_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = p_valid[i];
            bus.req_addr[i*3 +: 3]    = p_addr[i];
            bus.req_data[i*16 +: 16]  = p_data[i];
        end
        bus.wb_stall = stall_m;
    endtask

    task automatic model_reset();
        ptr_m     = 0;
        cnt_m     = 16'd0;
        exp_en    = 8'd0;
        exp_data  = 16'd0;
        exp_grant = 3'd0;
    endtask

    task automatic new_req(input int i, input logic [2:0] a, input logic [15:0] d);
        p_valid[i] = 1'b1;
        p_addr[i]  = a;
        p_data[i]  = d;
    endtask

    // Reset asserted with every requester valid; released with nothing pending.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) new_req(i, 3'(i), 16'(i + 1));
        stall_m = 1'b0;
        drive();
        #1;
        check_val("rst_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_reg_en", 32'(bus.reg_en), 32'd0);
        check_val("rst_count", 32'(bus.wb_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_wb_data", 32'(bus.wb_data), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
        drive();
    endtask

    task automatic step();
        int g;
        drive();
        #1;
        g = model_pick();
        check_val("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        if (g >= 0) begin
            exp_en    = 8'd1 << p_addr[g];
            exp_data  = p_data[g];
            exp_grant = 3'(g);
            rf_m[p_addr[g]] = p_data[g];
            p_valid[g] = 1'b0;
            cnt_m = cnt_m + 16'd1;
            ptr_m = (g + 1) % N;
        end else begin
            exp_en = 8'd0;
        end
        #1;
        check_val("reg_en", 32'(bus.reg_en), 32'(exp_en));
        check_val("wb_data", 32'(bus.wb_data), 32'(exp_data));
        check_val("wb_grant", 32'(bus.wb_grant), 32'(exp_grant));
        check_val("wb_count", 32'(bus.wb_count), 32'(cnt_m));
        for (int r = 0; r < 8; r++) if (bus.reg_en[r]) rf_d[r] = bus.wb_data;
        if (g >= 0)
            $display("write req%0d r%0d <= 0x%04h count=%0d", g, exp_en == 0 ? 0 : $clog2(exp_en),
                     exp_data, cnt_m);
        else
            $display("idle stall=%0d count=%0d", stall_m, cnt_m);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 8; r++) begin
            rf_m[r] = 16'd0;
            rf_d[r] = 16'd0;
        end
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0;
            p_addr[i]  = 3'd0;
            p_data[i]  = 16'd0;
        end
        stall_m = 1'b0;
        drive();

        // Reset with all valid, then req0 first after release
        do_reset();
        for (int i = 0; i < N; i++) new_req(i, 3'(i + 1), 16'hA000 + 16'(i));
        step();
        check_val("first_grant", 32'(bus.wb_grant), 32'd0);

        // Single write from req1
        do_reset();
        new_req(1, 3'd5, 16'hBEEF);
        step();
        check_val("single_en", 32'(bus.reg_en), 32'h20);
        check_val("single_data", 32'(bus.wb_data), 32'hBEEF);
        check_val("single_grant", 32'(bus.wb_grant), 32'd1);
        step();
        check_val("single_after", 32'(bus.reg_en), 32'd0);

        // Contention: both requesters held valid for four cycles
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++)
                if (!p_valid[i]) new_req(i, 3'($urandom_range(0, 7)), 16'($urandom));
            step();
`ifdef RR_ARB_EN
            check_val("contend_grant", 32'(bus.wb_grant), 32'(c % 2));
`else
            check_val("contend_grant", 32'(bus.wb_grant), 32'd0);
`endif
        end
        check_val("contend_count", 32'(bus.wb_count), 32'd4);

        // Same destination from both requesters in one cycle
        do_reset();
        new_req(0, 3'd2, 16'h1111);
        new_req(1, 3'd2, 16'h2222);
        step();
        check_val("samedst_en0", 32'(bus.reg_en), 32'h04);
        step();
        check_val("samedst_en1", 32'(bus.reg_en), 32'h04);
        check_val("samedst_final", 32'(rf_d[2]), 32'h2222);

        // Stall for three cycles with req0 pending
        do_reset();
        new_req(0, 3'd6, 16'h5A5A);
        stall_m = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("stall_en", 32'(bus.reg_en), 32'd0);
        end
        stall_m = 1'b0;
        step();
        check_val("unstall_en", 32'(bus.reg_en), 32'h40);

        // Reset in the cycle after an accept discards the presented write
        do_reset();
        new_req(0, 3'd1, 16'hC0DE);
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("midrst_en", 32'(bus.reg_en), 32'd0);
        check_val("midrst_count", 32'(bus.wb_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!p_valid[i] && $urandom_range(0, 99) < 60)
                    new_req(i, 3'($urandom_range(0, 7)), 16'($urandom));
            stall_m = ($urandom_range(0, 99) < 20);
            step();
        end
        stall_m = 1'b0;
        for (int r = 0; r < 8; r++) check_val("regfile_image", 32'(rf_d[r]), 32'(rf_m[r]));

        // Counter wrap after 65536 accepts
        do_reset();
        new_req(0, 3'd3, 16'h1234);
        drive();
        repeat (65535) @(posedge clk);
        #1;
        check_val("count_ffff", 32'(bus.wb_count), 32'hFFFF);
        @(posedge clk);
        #1;
        check_val("count_wrap", 32'(bus.wb_count), 32'd0);
        check_val("wrap_en", 32'(bus.reg_en), 32'h08);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
